wdt_multich: RTL and testbench

//  Multi-channel windowed watchdog; successor to the single-channel WDT.
//  NUM_CH independent channels share one prescaler. Per channel: timeout and

---
 rtl/wdt_multich.sv | 141 ++++++++++++++
 tb/tb_wdt_multich.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wdt_multich.sv
// Multi-channel windowed watchdog: one shared prescaler, per-channel timeout/window
// registers and IDLE/RUN/EXPIRED FSM, sticky timeout/early flags and a combined irq.
module wdt_multich #(
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 32,
   parameter int PRESC_W = 16,
   parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_CH-1:0]  ch_en,
   input  logic [NUM_CH-1:0]  ch_kick,
   input  logic               cfg_we,
   input  logic [CH_W-1:0]    cfg_ch,
   input  logic [CNT_W-1:0]   cfg_tocnt,
   input  logic [CNT_W-1:0]   cfg_win,
   input  logic [PRESC_W-1:0] presc_div,
   input  logic [NUM_CH-1:0]  wto_clr,
   output logic [NUM_CH-1:0]  wto,
   output logic [NUM_CH-1:0]  early,
   output logic               irq
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_EXPIRED = 2'd2
   } state_t;

   logic [PRESC_W-1:0] pc_reg, pc_next;
   logic               tick;
   logic               irq_reg;

   // A divider lowered below the current count restarts the prescaler.
   always_comb begin
      tick    = (pc_reg == presc_div);
      pc_next = pc_reg + 1'b1;
      if (tick || (pc_reg > presc_div)) begin
         pc_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_reg  <= '0;
         irq_reg <= 1'b0;
      end else begin
         pc_reg  <= pc_next;
         irq_reg <= |(wto | early);
      end
   end

   assign irq = irq_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         state_t           state_reg, state_next;
         logic [CNT_W-1:0] cnt_reg, cnt_next;
         logic [CNT_W-1:0] tocnt_reg, win_reg;
         logic             wto_reg, wto_next;
         logic             early_reg, early_next;
         logic             set_wto, set_early;
         logic             cfg_hit;
         logic [CNT_W:0]   cnt_inc;

         // Full-width compare so out-of-range indices match no channel.
         assign cfg_hit = cfg_we && (32'(cfg_ch) == gi);
         assign cnt_inc = {1'b0, cnt_reg} + (CNT_W+1)'(1);

         always_comb begin
            state_next = state_reg;
            cnt_next   = cnt_reg;
            set_wto    = 1'b0;
            set_early  = 1'b0;
            case (state_reg)
               ST_IDLE: begin
                  cnt_next = '0;
                  if (ch_en[gi] && (tocnt_reg != '0)) begin
                     state_next = ST_RUN;
                  end
               end
               ST_RUN: begin
                  if (!ch_en[gi] || (tocnt_reg == '0)) begin
                     state_next = ST_IDLE;
                     cnt_next   = '0;
                  end else if (ch_kick[gi]) begin
                     cnt_next = '0;
                     if ((win_reg != '0) && (cnt_reg < win_reg)) begin
                        set_early = 1'b1;
                     end
                  end else if (tick) begin
                     cnt_next = cnt_inc[CNT_W-1:0];
                     if (cnt_inc >= {1'b0, tocnt_reg}) begin
                        set_wto    = 1'b1;
                        state_next = ST_EXPIRED;
                     end
                  end
               end
               ST_EXPIRED: begin
                  if (wto_clr[gi]) begin
                     state_next = ST_IDLE;
                     cnt_next   = '0;
                  end
               end
               default: begin
                  state_next = ST_IDLE;
                  cnt_next   = '0;
               end
            endcase
            // A set event in the same cycle as a clear keeps the flag high.
            wto_next   = set_wto   | (wto_reg   & ~wto_clr[gi]);
            early_next = set_early | (early_reg & ~wto_clr[gi]);
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               state_reg <= ST_IDLE;
               cnt_reg   <= '0;
               tocnt_reg <= '0;
               win_reg   <= '0;
               wto_reg   <= 1'b0;
               early_reg <= 1'b0;
            end else begin
               state_reg <= state_next;
               cnt_reg   <= cnt_next;
               wto_reg   <= wto_next;
               early_reg <= early_next;
               if (cfg_hit) begin
                  tocnt_reg <= cfg_tocnt;
                  win_reg   <= cfg_win;
               end
            end
         end

         assign wto[gi]   = wto_reg;
         assign early[gi] = early_reg;
      end
   endgenerate

endmodule

// File: tb/tb_wdt_multich.sv
// Directed bench for wdt_multich: four channels, cfg_ch widened to 3 bits so an
// out-of-range channel index can be driven.
module tb_wdt_multich;
   localparam int NUM_CH  = 4;
   localparam int CNT_W   = 32;
   localparam int PRESC_W = 16;
   localparam int CH_W    = 3;

   logic               clk = 1'b0;
   logic               rst;
   logic [NUM_CH-1:0]  ch_en, ch_kick, wto_clr, wto, early;
   logic               cfg_we;
   logic [CH_W-1:0]    cfg_ch;
   logic [CNT_W-1:0]   cfg_tocnt, cfg_win;
   logic [PRESC_W-1:0] presc_div;
   logic               irq;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   wdt_multich #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W), .CH_W(CH_W)
   ) dut (
      .clk(clk), .rst(rst), .ch_en(ch_en), .ch_kick(ch_kick), .cfg_we(cfg_we),
      .cfg_ch(cfg_ch), .cfg_tocnt(cfg_tocnt), .cfg_win(cfg_win),
      .presc_div(presc_div), .wto_clr(wto_clr), .wto(wto), .early(early), .irq(irq)
   );

   // Outputs are sampled 1 time unit after the edge; cyc numbers edges since reset.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset(input logic [PRESC_W-1:0] div);
      rst = 1'b1; ch_en = '0; ch_kick = '0; wto_clr = '0;
      cfg_we = 1'b0; cfg_ch = '0; cfg_tocnt = '0; cfg_win = '0;
      presc_div = div;
      step();
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic cfg_write(input int ch, input logic [CNT_W-1:0] to, input logic [CNT_W-1:0] win);
      cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_tocnt = to; cfg_win = win;
      step();
      cfg_we = 1'b0;
      $display("cfg   ch=%0d tocnt=%0d win=%0d (edge %0d)", ch, to, win, cyc);
   endtask

   task automatic test_reset();
      do_reset('0);
      n_cmp++; if (wto !== 4'b0000) begin n_err++; $display("FAIL reset_wto: got %b want 0000", wto); end
      n_cmp++; if (early !== 4'b0000) begin n_err++; $display("FAIL reset_early: got %b want 0000", early); end
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
      ch_en = 4'b1111;
      for (int i = 0; i < 8; i++) step();
      n_cmp++; if (wto !== 4'b0000) begin n_err++; $display("FAIL unconfigured_idle: wto=%b want 0000", wto); end
      $display("test_reset done");
   endtask

   task automatic test_timeout();
      do_reset('0);
      cfg_write(0, 5, 0);
      ch_en = 4'b0001;
      for (int i = 0; i < 5; i++) step();      // edge 6
      n_cmp++; if (wto !== 4'b0000) begin n_err++; $display("FAIL t1_wto_early: wto=%b want 0000", wto); end
      step();                                   // edge 7: 5th tick after RUN entry
      n_cmp++; if (wto !== 4'b0001) begin n_err++; $display("FAIL t1_wto_set: wto=%b want 0001", wto); end
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL t1_irq_lag: irq=%b want 0", irq); end
      step();
      n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL t1_irq_set: irq=%b want 1", irq); end
      wto_clr = 4'b0001; ch_en = 4'b0000;
      step();
      wto_clr = 4'b0000;
      n_cmp++; if (wto !== 4'b0000) begin n_err++; $display("FAIL t1_wto_clr: wto=%b want 0000", wto); end
      step();
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL t1_irq_clr: irq=%b want 0", irq); end
      $display("test_timeout done");
   endtask

   task automatic test_prescaler();
      logic bad;
      do_reset(16'd3);
      cfg_write(1, 2, 0);
      ch_en = 4'b0010;
      for (int i = 0; i < 6; i++) step();      // edges 2..7, ticks at 4 and 8
      n_cmp++; if (wto !== 4'b0000) begin n_err++; $display("FAIL t2_wto_early: wto=%b want 0000", wto); end
      step();
      n_cmp++; if (wto !== 4'b0010) begin n_err++; $display("FAIL t2_wto_set: wto=%b want 0010", wto); end

      do_reset(16'd3);
      cfg_write(1, 2, 0);
      ch_en = 4'b0010;
      bad = 1'b0;
      while (cyc < 61) begin
         ch_kick = ((cyc + 1) > 2 && ((cyc + 1) % 6 == 2)) ? 4'b0010 : 4'b0000;
         step();
         if (wto !== 4'b0000) bad = 1'b1;
      end
      ch_kick = 4'b0000;
      n_cmp++; if (bad !== 1'b0) begin n_err++; $display("FAIL t2_kicked_no_wto: seen_wto=%b want 0", bad); end
      while (cyc < 63) step();
      n_cmp++; if (wto !== 4'b0000) begin n_err++; $display("FAIL t2_after_kicks_early: wto=%b want 0000", wto); end
      step();                                   // edge 64: second tick since last kick
      n_cmp++; if (wto !== 4'b0010) begin n_err++; $display("FAIL t2_after_kicks_set: wto=%b want 0010", wto); end
      $display("test_prescaler done");
   endtask

   task automatic test_window();
      do_reset('0);
      cfg_write(2, 10, 4);
      ch_en = 4'b0100;
      step(); step(); step();                   // edge 4: cnt=2
      ch_kick = 4'b0100; wto_clr = 4'b0100;     // early kick with a coincident clear
      step();
      ch_kick = 4'b0000; wto_clr = 4'b0000;
      n_cmp++; if (early !== 4'b0100) begin n_err++; $display("FAIL t3_early_set: early=%b want 0100", early); end
      n_cmp++; if (wto !== 4'b0000) begin n_err++; $display("FAIL t3_no_wto: wto=%b want 0000", wto); end
      wto_clr = 4'b0100;
      step();                                   // edge 6: cnt=1
      wto_clr = 4'b0000;
      n_cmp++; if (early !== 4'b0000) begin n_err++; $display("FAIL t3_early_clr: early=%b want 0000", early); end
      for (int i = 0; i < 5; i++) step();      // edge 11: cnt=6
      ch_kick = 4'b0100;
      step();
      ch_kick = 4'b0000;
      n_cmp++; if (early !== 4'b0000) begin n_err++; $display("FAIL t3_late_kick: early=%b want 0000", early); end
      for (int i = 0; i < 4; i++) step();      // edge 16: cnt=4 == win
      ch_kick = 4'b0100;
      step();
      ch_kick = 4'b0000;
      n_cmp++; if (early !== 4'b0000) begin n_err++; $display("FAIL t3_kick_at_win: early=%b want 0000", early); end
      for (int i = 0; i < 9; i++) step();      // edge 26: cnt=9
      n_cmp++; if (wto !== 4'b0000) begin n_err++; $display("FAIL t3_wto_early: wto=%b want 0000", wto); end
      step();
      n_cmp++; if (wto !== 4'b0100) begin n_err++; $display("FAIL t3_wto_set: wto=%b want 0100", wto); end
      $display("test_window done");
   endtask

   task automatic test_kick_vs_tick();
      do_reset('0);
      cfg_write(0, 3, 0);
      ch_en = 4'b0001;
      step(); step(); step();                   // edge 4: cnt=2
      ch_kick = 4'b0001;
      step();                                   // edge 5: kick coincides with 3rd tick
      ch_kick = 4'b0000;
      n_cmp++; if (wto !== 4'b0000) begin n_err++; $display("FAIL t4_kick_wins: wto=%b want 0000", wto); end
      step(); step();
      n_cmp++; if (wto !== 4'b0000) begin n_err++; $display("FAIL t4_cnt_cleared: wto=%b want 0000", wto); end
      step();
      n_cmp++; if (wto !== 4'b0001) begin n_err++; $display("FAIL t4_wto_set: wto=%b want 0001", wto); end
      wto_clr = 4'b0001;
      step();                                   // edge 9: EXPIRED -> IDLE
      wto_clr = 4'b0000;
      n_cmp++; if (wto !== 4'b0000) begin n_err++; $display("FAIL t4_wto_clr: wto=%b want 0000", wto); end
      step(); step(); step();                   // edge 12: RUN, cnt=2
      wto_clr = 4'b0001;
      step();                                   // edge 13: timeout with clear
      wto_clr = 4'b0000;
      n_cmp++; if (wto !== 4'b0001) begin n_err++; $display("FAIL t4_set_beats_clr: wto=%b want 0001", wto); end
      step();
      n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL t4_irq: irq=%b want 1", irq); end
      $display("test_kick_vs_tick done");
   endtask

   task automatic test_rearm();
      do_reset('0);
      cfg_write(3, 2, 0);
      ch_en = 4'b1000;
      step(); step(); step();                   // edge 4
      n_cmp++; if (wto !== 4'b1000) begin n_err++; $display("FAIL t5_first_wto: wto=%b want 1000", wto); end
      wto_clr = 4'b1000;
      step();
      wto_clr = 4'b0000;
      n_cmp++; if (wto !== 4'b0000) begin n_err++; $display("FAIL t5_clr: wto=%b want 0000", wto); end
      step(); step();                           // edge 7
      n_cmp++; if (wto !== 4'b0000) begin n_err++; $display("FAIL t5_rearm_early: wto=%b want 0000", wto); end
      step();
      n_cmp++; if (wto !== 4'b1000) begin n_err++; $display("FAIL t5_refire: wto=%b want 1000", wto); end
      wto_clr = 4'b1000;
      step();
      wto_clr = 4'b0000;
      step();                                   // edge 10: RUN
      cfg_write(3, 0, 0);                       // edge 11
      for (int i = 0; i < 4; i++) step();      // edge 15
      n_cmp++; if (wto !== 4'b0000) begin n_err++; $display("FAIL t5_tocnt0_idle: wto=%b want 0000", wto); end
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL t5_tocnt0_irq: irq=%b want 0", irq); end
      $display("test_rearm done");
   endtask

   task automatic test_tocnt_shrink();
      do_reset('0);
      cfg_write(0, 100, 0);
      ch_en = 4'b0001;
      for (int i = 0; i < 6; i++) step();      // edge 7: cnt=5
      cfg_write(0, 3, 0);                       // edge 8: cnt=6, tocnt now 3
      n_cmp++; if (wto !== 4'b0000) begin n_err++; $display("FAIL shrink_before: wto=%b want 0000", wto); end
      step();
      n_cmp++; if (wto !== 4'b0001) begin n_err++; $display("FAIL shrink_next_tick: wto=%b want 0001", wto); end
      $display("test_tocnt_shrink done");
   endtask

   task automatic test_reset_midrun();
      do_reset('0);
      cfg_write(0, 2, 0);
      cfg_write(1, 50, 0);
      cfg_write(2, 50, 5);
      cfg_write(3, 50, 0);
      ch_en = 4'b1111;
      step();                                   // edge 5: all RUN
      ch_kick = 4'b0100;
      step();
      ch_kick = 4'b0000;
      step();                                   // edge 7
      n_cmp++; if (wto !== 4'b0001) begin n_err++; $display("FAIL t6_pre_wto: wto=%b want 0001", wto); end
      n_cmp++; if (early !== 4'b0100) begin n_err++; $display("FAIL t6_pre_early: early=%b want 0100", early); end
      step();
      n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL t6_pre_irq: irq=%b want 1", irq); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_cmp++; if (wto !== 4'b0000) begin n_err++; $display("FAIL t6_rst_wto: wto=%b want 0000", wto); end
      n_cmp++; if (early !== 4'b0000) begin n_err++; $display("FAIL t6_rst_early: early=%b want 0000", early); end
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL t6_rst_irq: irq=%b want 0", irq); end
      for (int i = 0; i < 10; i++) step();
      n_cmp++; if (wto !== 4'b0000) begin n_err++; $display("FAIL t6_config_lost: wto=%b want 0000", wto); end
      $display("test_reset_midrun done");
   endtask

   task automatic test_cfg_range();
      do_reset('0);
      cfg_write(1, 3, 0);
      ch_en = 4'b1111;
      cfg_write(5, 1, 0);                       // edge 2: ch1 enters RUN
      step(); step();                           // edge 4
      n_cmp++; if (wto !== 4'b0000) begin n_err++; $display("FAIL t6_cfg5_ignored: wto=%b want 0000", wto); end
      step();
      n_cmp++; if (wto !== 4'b0010) begin n_err++; $display("FAIL t6_cfg5_ch1_intact: wto=%b want 0010", wto); end
      $display("test_cfg_range done");
   endtask

   initial begin
      test_reset();
      test_timeout();
      test_prescaler();
      test_window();
      test_kick_vs_tick();
      test_rearm();
      test_tocnt_shrink();
      test_reset_midrun();
      test_cfg_range();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
